// File: rtl/sixteen_bit_1x16_demux_latch.sv
// Registered 1-to-16 demultiplexer: writes land in per-channel shadow registers,
// and a commit copies every shadow register to the outputs on the same edge.
module sixteen_bit_1x16_demux_latch #(
  parameter int WIDTH       = 16,
  parameter int AUTO_COMMIT = 0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [3:0]       i_select,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_write,
  input  logic             i_commit,
  output logic [WIDTH-1:0] o_0,
  output logic [WIDTH-1:0] o_1,
  output logic [WIDTH-1:0] o_2,
  output logic [WIDTH-1:0] o_3,
  output logic [WIDTH-1:0] o_4,
  output logic [WIDTH-1:0] o_5,
  output logic [WIDTH-1:0] o_6,
  output logic [WIDTH-1:0] o_7,
  output logic [WIDTH-1:0] o_8,
  output logic [WIDTH-1:0] o_9,
  output logic [WIDTH-1:0] o_A,
  output logic [WIDTH-1:0] o_B,
  output logic [WIDTH-1:0] o_C,
  output logic [WIDTH-1:0] o_D,
  output logic [WIDTH-1:0] o_E,
  output logic [WIDTH-1:0] o_F,
  output logic [15:0]      o_dirty,
  output logic             o_commit_done
);

  // Handshake: there is no ready; a write with i_write high is always accepted
  // on that edge, and i_select/i_data are ignored while i_write is low.
  logic [WIDTH-1:0] shadow_q [16];
  logic [WIDTH-1:0] shadow_d [16];
  logic [WIDTH-1:0] out_q    [16];
  logic [WIDTH-1:0] out_d    [16];
  logic [15:0]      dirty_q;
  logic [15:0]      dirty_d;
  logic             commit_done_q;
  logic             commit_done_d;
  logic             commit_eff;

  always_comb begin
    commit_eff = i_commit | ((AUTO_COMMIT != 0) & i_write & (i_select == 4'hF));
    dirty_d    = dirty_q;
    for (int n = 0; n < 16; n++) begin
      shadow_d[n] = shadow_q[n];
    end
    if (i_write) begin
      shadow_d[i_select] = i_data;
      dirty_d[i_select]  = 1'b1;
    end
    // Commit takes the post-write shadow so a same-cycle write is bypassed through.
    for (int n = 0; n < 16; n++) begin
      out_d[n] = commit_eff ? shadow_d[n] : out_q[n];
    end
    if (commit_eff) begin
      dirty_d = '0;
    end
    commit_done_d = commit_eff;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int n = 0; n < 16; n++) begin
        shadow_q[n] <= '0;
        out_q[n]    <= '0;
      end
      dirty_q       <= '0;
      commit_done_q <= 1'b0;
    end else begin
      for (int n = 0; n < 16; n++) begin
        shadow_q[n] <= shadow_d[n];
        out_q[n]    <= out_d[n];
      end
      dirty_q       <= dirty_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign o_0           = out_q[0];
  assign o_1           = out_q[1];
  assign o_2           = out_q[2];
  assign o_3           = out_q[3];
  assign o_4           = out_q[4];
  assign o_5           = out_q[5];
  assign o_6           = out_q[6];
  assign o_7           = out_q[7];
  assign o_8           = out_q[8];
  assign o_9           = out_q[9];
  assign o_A           = out_q[10];
  assign o_B           = out_q[11];
  assign o_C           = out_q[12];
  assign o_D           = out_q[13];
  assign o_E           = out_q[14];
  assign o_F           = out_q[15];
  assign o_dirty       = dirty_q;
  assign o_commit_done = commit_done_q;

endmodule

// File: doc/sixteen_bit_1x16_demux_latch.md
Name: sixteen_bit_1x16_demux_latch

Overview:
Registered 1-to-16 demultiplexer: the write-side counterpart of sixteen_bit_16x1_mux. One 16-bit input word is steered by a 4-bit select into one of 16 shadow registers. On commit, all 16 shadow registers copy into the 16 output registers in the same cycle, so every channel updates together. Sits between the voice/control-value generator and the per-channel consumers (DAC channels, per-voice parameter inputs).

Parameters:
WIDTH, 16, data width of the input word and of each channel.
AUTO_COMMIT, 0, when 1 a write to channel F also performs a commit in the same cycle.

Ports:
i_clock  input  1  system clock; all state changes on the rising edge.
i_reset  input  1  synchronous, active-high reset.
i_select  input  4  target channel for a write, 0..F.
i_data  input  WIDTH  word to write.
i_write  input  1  write strobe; one write per cycle while high.
i_commit  input  1  commit strobe: copy all shadow registers to the outputs.
o_0 .. o_F  output  WIDTH each  registered channel outputs (16 ports).
o_dirty  output  16  bit n set = channel n written since the last commit.
o_commit_done  output  1  one-cycle pulse, the cycle after a commit takes effect.

Behaviour:
- Reset (i_reset high at an edge): all shadow registers, o_0..o_F, o_dirty and o_commit_done go to 0. Reset overrides write and commit in that cycle. Reset mid-sequence discards any uncommitted shadow data.
- Write: with i_write high at an edge, shadow[i_select] <= i_data and o_dirty[i_select] <= 1. The outputs do not change on a write.
- Commit: the effective commit is i_commit, ORed with (AUTO_COMMIT and i_write and i_select == 4'hF).
  - On an effective commit, every o_n <= next shadow value for channel n.
  - Write + commit in the same cycle: the written word is bypassed into the commit, so the target output shows i_data after one edge.
  - Latency: commit to outputs is 1 clock.
  - o_commit_done is high for exactly the following cycle.
- o_dirty on commit: cleared to 0, including any bit set by a simultaneous write, because that data is committed.
- Repeated commits with no writes: outputs are unchanged, o_commit_done pulses each time, and o_dirty stays 0.
- Back-to-back writes to the same channel before a commit: the last write wins.
- Writes to different channels: independent; no state machine stalls and no ready signal. The block always accepts a write.
- i_select is fully decoded (all 16 values are valid) and has no wrap or overflow case.
- With i_write low, i_select and i_data are don't-care.

Test Plan:
- Reset, then write i_select=3, i_data=16'h3333 with no commit -> o_3 stays 16'h0000 and o_dirty=16'h0008; pulse i_commit -> the next cycle o_3=16'h3333, o_dirty=0, o_commit_done=1 for one cycle.
- Write 16'h0000, 16'h1111 … 16'hFFFF to channels 0..F over 16 cycles, then commit -> all outputs update on the same edge, o_n = n replicated across every nibble, o_dirty goes 16'hFFFF -> 0.
- Write channel 5 = 16'hAAAA, then 16'h5555 in consecutive cycles, then commit -> o_5=16'h5555.
- i_write with i_select=7, i_data=16'h1234 and i_commit in the same cycle -> o_7=16'h1234 after one edge, o_dirty=0.
- AUTO_COMMIT=1: write channel 2 = 16'h2222 (outputs unchanged), then channel F = 16'hFFFF -> o_2=16'h2222 and o_F=16'hFFFF on the same edge, o_commit_done pulses. With AUTO_COMMIT=0 the same stimulus produces no output change.
- Commit everything nonzero, write channel 9, then assert i_reset together with i_commit -> all outputs and o_dirty become 0 and o_commit_done stays 0.
